// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Shares the 8-digit seven-segment display between three sources: the CPU
// output register, the keypad echo and the toggle-switch binary view.
// A fixed-priority arbiter (switch > keypad > CPU) picks an owner when idle and
// again at every frame end. Decimal sources are converted to BCD with a
// sequential shift-add-3 (one bit per clock). The digit scan then drives
// active-low enables with leading-zero blanking.
//
// Request/grant contract: req bits are levels, not pulses. They are sampled
// only while IDLE and on the last cycle of a scan frame. grant is one-hot (or
// zero) and changes only on those same edges. The winner's data is latched on
// the granting edge, so later changes to req or data are ignored until the
// next frame end.
//
// fsm_state exposes the controller state for observation:
// 0 = IDLE, 1 = CONVERT, 2 = DISPLAY.
module seg_display_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 4
) (
  input  logic                  clk_tube,
  input  logic                  rst_n,
  input  logic [2:0]            req,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  input  logic [DATA_WIDTH-1:0] keypad_data,
  input  logic [23:0]           switch_map,
  output logic [2:0]            grant,
  output logic                  busy,
  output logic [3:0]            digit_bcd,
  output logic [DIGITS-1:0]     seg_enable,
  output logic [1:0]            fsm_state
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DISPLAY = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]            grant_q, grant_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;       // value being shifted out MSB first
  logic [BCD_W-1:0]      bcd_q, bcd_d;           // conversion accumulator
  logic [CNT_W-1:0]      conv_cnt_q, conv_cnt_d; // conversion step number
  logic [BCD_W-1:0]      buf_q, buf_d;           // display buffer being scanned
  logic [DIGITS-1:0]     blank_q, blank_d;       // 1 = digit blanked
  logic                  shown_q, shown_d;       // display buffer valid, scan running

  logic [IDX_W-1:0]      idx_q;
  logic [DIV_W-1:0]      div_q;

  logic [2:0]            win;
  logic                  arbitrate;
  logic                  frame_end;
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W-1:0]      bcd_step;
  logic [BCD_W-1:0]      bin_buf;

  // Digits above the most significant nonzero digit are blanked.
  // Digit 0 is never blanked, so the value 0 still shows a single "0".
  function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] v);
    logic [DIGITS-1:0] m;
    logic              found;
    m     = '0;
    found = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (v[4*i +: 4] != 4'd0) found = 1'b1;
      m[i] = ~found;
    end
    return m;
  endfunction

  // Fixed priority: switch (bit2) over keypad (bit1) over CPU (bit0).
  always_comb begin
    win = 3'b000;
    if (req[2])      win = 3'b100;
    else if (req[1]) win = 3'b010;
    else if (req[0]) win = 3'b001;
  end

  // The frame ends on the last clock of the last digit slot.
  // Blanked digits still use their slot.
  assign frame_end = shown_q && (idx_q == IDX_LAST) && (div_q == DIV_LAST);

  // One double-dabble step. Any digit of 5 or more gets 3 added before the
  // shift. Carries out of the top digit are dropped, so the result is the
  // value mod 10^DIGITS.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
  end

  assign bcd_step = {bcd_adj[BCD_W-2:0], shreg_q[DATA_WIDTH-1]};

  // The switch view puts one switch level on each digit, as the value 0 or 1.
  always_comb begin
    bin_buf = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bin_buf[4*i +: 4] = {3'b000, switch_map[i]};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_tube or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 3'b000;
      shreg_q    <= '0;
      bcd_q      <= '0;
      conv_cnt_q <= '0;
      buf_q      <= '0;
      blank_q    <= '0;
      shown_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      conv_cnt_q <= conv_cnt_d;
      buf_q      <= buf_d;
      blank_q    <= blank_d;
      shown_q    <= shown_d;
    end
  end

  // Next-state logic: arbitration, conversion steps and buffer writes.
  // Re-arbitration happens only at a frame end reached in DISPLAY. A frame end
  // that falls during a conversion lets the conversion finish first.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    conv_cnt_d = conv_cnt_q;
    buf_d      = buf_q;
    blank_d    = blank_q;
    shown_d    = shown_q;
    arbitrate  = 1'b0;

    case (state_q)
      IDLE: begin
        arbitrate = |req;
      end
      CONVERT: begin
        shreg_d    = shreg_q << 1;
        bcd_d      = bcd_step;
        conv_cnt_d = conv_cnt_q + 1'b1;
        if (conv_cnt_q == CONV_LAST) begin
          // The last step writes the display buffer on the same edge that
          // busy falls.
          buf_d   = bcd_step;
          blank_d = blank_of(bcd_step);
          shown_d = 1'b1;
          state_d = DISPLAY;
        end
      end
      DISPLAY: begin
        if (frame_end) begin
          if (|req) begin
            arbitrate = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = 3'b000;
            shown_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (arbitrate) begin
      grant_d = win;
      if (win[2]) begin
        buf_d   = bin_buf;
        blank_d = '0;
        shown_d = 1'b1;
        state_d = DISPLAY;
      end else begin
        shreg_d    = win[1] ? keypad_data : cpu_data;
        bcd_d      = '0;
        conv_cnt_d = '0;
        state_d    = CONVERT;
      end
    end
  end

  // Scan counters run only while a valid buffer is on display.
  // Otherwise they are held at digit 0, so a new display starts at digit 0.
  always_ff @(posedge clk_tube or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      div_q <= '0;
    end else if (!shown_q) begin
      idx_q <= '0;
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Digit mux and active-low enable for the current scan position.
  always_comb begin
    digit_bcd  = 4'd0;
    seg_enable = '1;
    if (shown_q) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          digit_bcd     = buf_q[4*i +: 4];
          seg_enable[i] = blank_q[i];
        end
      end
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == CONVERT);
  assign fsm_state = state_q;

  // Switch levels above the digit count are not shown.
  // The top adjusted bit always shifts out of the accumulator.
  logic unused_ok;
  assign unused_ok = ^{switch_map[23:DIGITS], bcd_adj[BCD_W-1]};

endmodule
